// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory port arbiter.
// Modport slave is the arbiter's view; master is the requesters/memory view.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 256
);
    logic                  i_req;
    logic [WORD_SIZE-1:0]  i_addr;
    logic                  i_gnt;
    logic                  i_done;
    logic [BLOCK_SIZE-1:0] i_data0;
    logic [BLOCK_SIZE-1:0] i_data1;

    logic                  d_req;
    logic                  d_we;
    logic [WORD_SIZE-1:0]  d_addr;
    logic [BLOCK_SIZE-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_done;
    logic [BLOCK_SIZE-1:0] d_rdata;

    logic                  err;

    logic                  mem_en;
    logic                  mem_we;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic [BLOCK_SIZE-1:0] mem_wdata;
    logic [BLOCK_SIZE-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_gnt, i_done, i_data0, i_data1,
        output d_gnt, d_done, d_rdata, err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_gnt, i_done, i_data0, i_data1,
        input  d_gnt, d_done, d_rdata, err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port: I-side paired block refill vs D-side block access.
// Ports: clk, rst_n (async active-low), bus (mem_port_arbiter_if.slave) with requester and memory sides.
module mem_port_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 256,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.slave     bus
);
    localparam int BLK_BYTES = BLOCK_SIZE / 8;
    localparam int CNT_W     = $clog2(TIMEOUT + 1);

    localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'(BLK_BYTES - 1);
    localparam logic [WORD_SIZE-1:0] BLK_STEP = WORD_SIZE'(BLK_BYTES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_I_FETCH0,
        S_I_FETCH1,
        S_D_ACCESS,
        S_DONE
    } state_e;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } side_e;

    state_e                state_q, state_d;
    side_e                 last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  to_q, to_d;
    logic [BLOCK_SIZE-1:0] i_data0_q, i_data0_d;
    logic [BLOCK_SIZE-1:0] i_data1_q, i_data1_d;
    logic [BLOCK_SIZE-1:0] d_rdata_q, d_rdata_d;

    logic [WORD_SIZE-1:0]  i_blk;
    logic [WORD_SIZE-1:0]  d_blk;
    logic                  in_mem;

    assign i_blk  = bus.i_addr & ~OFF_MASK;
    assign d_blk  = bus.d_addr & ~OFF_MASK;
    assign in_mem = (state_q == S_I_FETCH0) || (state_q == S_I_FETCH1) ||
                    (state_q == S_D_ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= SIDE_D;
            cnt_q     <= '0;
            to_q      <= 1'b0;
            i_data0_q <= '0;
            i_data1_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            i_data0_q <= i_data0_d;
            i_data1_q <= i_data1_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        i_data0_d = i_data0_q;
        i_data1_d = i_data1_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // On a tie the side that was not served last wins.
                if (bus.i_req && (!bus.d_req || last_q == SIDE_D)) begin
                    state_d = S_I_FETCH0;
                    last_d  = SIDE_I;
                    to_d    = 1'b0;
                end else if (bus.d_req) begin
                    state_d = S_D_ACCESS;
                    last_d  = SIDE_D;
                    to_d    = 1'b0;
                end
            end
            S_I_FETCH0, S_I_FETCH1, S_D_ACCESS: begin
                if (bus.mem_ready) begin
                    cnt_d = '0;
                    if (state_q == S_I_FETCH0) begin
                        i_data0_d = bus.mem_rdata;
                        state_d   = S_I_FETCH1;
                    end else if (state_q == S_I_FETCH1) begin
                        i_data1_d = bus.mem_rdata;
                        state_d   = S_DONE;
                    end else begin
                        if (!bus.d_we) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                        state_d = S_DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abort; an I pair aborted in FETCH0 never issues FETCH1.
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state and live requester inputs.
    always_comb begin
        bus.mem_addr = '0;
        unique case (state_q)
            S_I_FETCH0: bus.mem_addr = i_blk;
            S_I_FETCH1: bus.mem_addr = i_blk + BLK_STEP;
            S_D_ACCESS: bus.mem_addr = d_blk;
            default:    bus.mem_addr = '0;
        endcase
    end

    assign bus.mem_en    = in_mem;
    assign bus.mem_we    = (state_q == S_D_ACCESS) && bus.d_we;
    assign bus.mem_wdata = (state_q == S_D_ACCESS) ? bus.d_wdata : '0;

    assign bus.i_gnt  = (state_q == S_I_FETCH0) || (state_q == S_I_FETCH1);
    assign bus.d_gnt  = (state_q == S_D_ACCESS);
    assign bus.i_done = (state_q == S_DONE) && (last_q == SIDE_I);
    assign bus.d_done = (state_q == S_DONE) && (last_q == SIDE_D);
    assign bus.err    = (state_q == S_DONE) && to_q;

    assign bus.i_data0 = i_data0_q;
    assign bus.i_data1 = i_data1_q;
    assign bus.d_rdata = d_rdata_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single backing-memory port between the instruction-cache refill path and the data-cache access path. An I-side miss is served as a paired fetch of the addressed block and the next block, which the instruction cache needs for unaligned fetches that straddle two blocks. A D-side request is served as one block read or write. Arbitration is round-robin, and a wait-cycle counter aborts accesses the memory never acknowledges.

## Interface
- `WORD_SIZE`, 32: address width.
- `BLOCK_SIZE`, 256: block width in bits, 32 bytes; the low 5 address bits are the offset.
- `TIMEOUT`, 64: maximum cycles an access waits for `mem_ready` before it is aborted.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  I-side refill request; level; held until `i_done`.
- `i_addr`  in  WORD_SIZE  I-side miss address; must stay stable while `i_req` is high.
- `i_gnt`  out  1  high while the I-side transaction owns the port.
- `i_done`  out  1  one-cycle pulse; `i_data0` and `i_data1` are valid in that cycle.
- `i_data0`, `i_data1`  out  BLOCK_SIZE each  addressed block and next block.
- `d_req`, `d_we`  in  1 each  D-side request (level) and write select.
- `d_addr`  in  WORD_SIZE  D-side address.
- `d_wdata`  in  BLOCK_SIZE  D-side write data.
- `d_gnt`, `d_done`  out  1 each  grant (level) and completion (one-cycle pulse).
- `d_rdata`  out  BLOCK_SIZE  read data; valid with `d_done` when `d_we=0`.
- `err`  out  1  valid with either done pulse; 1 = the transaction timed out.
- `mem_en`, `mem_we`  out  1 each  memory access strobe and write select.
- `mem_addr`  out  WORD_SIZE  block-aligned memory address.
- `mem_wdata`  out  BLOCK_SIZE  memory write data.
- `mem_rdata`  in  BLOCK_SIZE  memory read data.
- `mem_ready`  in  1  memory acknowledge; data is consumed or captured at the edge where `mem_ready` is sampled high.

## Operation
- FSM states: IDLE, I_FETCH0, I_FETCH1, D_ACCESS, DONE.
- IDLE transitions:
  - Only `i_req` high -> I_FETCH0.
  - Only `d_req` high -> D_ACCESS.
  - Both high -> the side not served last wins.
  - `last_served` updates when a grant is taken. It resets to D, so the I side wins the first tie.
- I_FETCH0:
  - `mem_en=1`, `mem_we=0`, `mem_addr={i_addr[31:5],5'b0}`.
  - On `mem_ready`: capture `i_data0` and go to I_FETCH1.
- I_FETCH1:
  - `mem_addr` = previous block address + 32, modulo 2^32; 0xFFFFFFE0 wraps to 0x00000000.
  - `mem_en` stays high across the I_FETCH0 -> I_FETCH1 boundary.
  - On `mem_ready`: capture `i_data1` and go to DONE.
- D_ACCESS:
  - `mem_en=1`, `mem_we=d_we`, `mem_addr={d_addr[31:5],5'b0}`, `mem_wdata=d_wdata`.
  - On `mem_ready`: capture `d_rdata` if reading, then go to DONE.
- DONE:
  - Pulse the owner's `*_done` for one cycle, with `err` = the timeout flag.
  - Clear the grant and go to IDLE. A new grant is possible no earlier than the following cycle.
- Wait counter:
  - Cleared on entry to every memory state; increments each cycle `mem_ready` is low.
  - At `TIMEOUT`: drop `mem_en`, set the timeout flag and go to DONE. An I pair aborted in FETCH0 skips FETCH1.
  - Data from an aborted access is undefined.
- A request that drops mid-transaction does not abort it: the transaction completes and `done` still pulses.
- Requester inputs are sampled live, not latched. Inputs must stay stable until `done`.

## Timing
- Reset values:
  - State IDLE; `last_served`=D.
  - `i_gnt`, `d_gnt`, `i_done`, `d_done`, `err`, `mem_en`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `i_data0`, `i_data1`, `d_rdata` = 0.
- All outputs are registered or decoded from the registered state, with no combinational path from `mem_ready` to the outputs.
- Zero-wait memory (`mem_ready` high in the first `mem_en` cycle):
  - D side: request sampled at edge n, `mem_en` high during cycle n+1, `d_done` high during cycle n+2.
  - I side: `i_done` high during cycle n+3.
- Memory with W wait cycles per access adds W cycles to D and 2W to I.
- Back-to-back requests: the minimum gap between one transaction's done pulse and the next grant's `mem_en` is 1 cycle, spent in IDLE.
- Reset mid-transaction:
  - All outputs go to reset values immediately (asynchronous); no done pulse is issued.
  - A memory write in flight may or may not have completed.

## Test plan
- Single D read: `d_addr`=0x0000_0047, zero-wait memory returning 0xAB..AB -> `mem_addr`=0x40, `d_done` at n+2, `d_rdata`=0xAB..AB, `err`=0.
- I paired fetch with W=3: `i_addr`=0x0000_0105 -> `mem_addr` 0x100 then 0x120 with `mem_en` continuous, `i_done` at n+9, `i_data0`/`i_data1` match memory contents.
- Wrap-around: `i_addr`=0xFFFF_FFF0 -> second access at 0x0000_0000.
- Simultaneous `i_req` and `d_req` held high for 3 rounds -> grant order I, D, I; each done pulse is exactly 1 cycle.
- Timeout: `mem_ready` tied low, `TIMEOUT`=8 -> `mem_en` drops after 8 wait cycles, done pulse with `err`=1, FSM back in IDLE.
- `rst_n` low during I_FETCH1 -> `mem_en`, `i_gnt` = 0 immediately; after release, a fresh `d_req` is served normally.
